// File: rtl/fault_injector_if.sv
// Observed bus bundle: clean channel words in, fault-overlaid channel words out.
// Zero-latency combinational path through the injector; no flow control on this bus.
interface fault_injector_if #(
    parameter int WIDTH = 32,
    parameter int N_CH  = 8
);
    logic [N_CH*WIDTH-1:0] data_i;
    logic [N_CH*WIDTH-1:0] data_o;

    modport master (output data_i, input data_o);
    modport slave  (input data_i, output data_o);
endinterface

// File: rtl/fault_injector.sv
// LFSR-driven single-channel fault injector with detection-window bookkeeping.
// Overlay is combinational (zero latency); fire decisions register one cycle later; no backpressure.
module fault_injector #(
    parameter int          WIDTH       = 32,
    parameter int          N_CH        = 8,
    parameter int          HOLD_CYCLES = 1,
    parameter int          DET_WINDOW  = 16,
    parameter logic [31:0] SEED        = 32'hACE1_2F3B,
    localparam int         CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [1:0]            mode_i,
    input  logic [7:0]            threshold_i,
    input  logic [7:0]            budget_i,
    input  logic [31:0]           pc_i,
    input  logic [31:0]           pc_limit_i,
    fault_injector_if.slave       bus,
    input  logic                  error_i,
    output logic                  inject_o,
    output logic [CH_W-1:0]       inject_ch_o,
    output logic [4:0]            inject_bit_o,
    output logic [7:0]            inject_count_o,
    output logic [7:0]            detect_count_o,
    output logic [7:0]            miss_count_o,
    output logic                  done_o
);
    localparam int          BIT_W     = $clog2(WIDTH);
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_HOLD, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       lfsr_q, lfsr_nxt;
    logic [CH_W-1:0]   ch_q, ch_d, lfsr_ch;
    logic [4:0]        bit_q, bit_d, lfsr_bit;
    logic [1:0]        mode_q, mode_d;
    logic [WIDTH-1:0]  pat_q, pat_d, lfsr_pat;
    logic [7:0]        inj_cnt_q, inj_cnt_d, det_cnt_q, det_cnt_d, miss_cnt_q, miss_cnt_d;
    logic [7:0]        budget_q, budget_d;
    logic [15:0]       win_q, win_d, hold_q, hold_d;
    logic              detected_q, detected_d, err_prev_q, pulse_q, pulse_d;
    logic              fire, budget_spent, new_det, det_now, in_window_state;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
    assign lfsr_ch  = (N_CH == 1) ? '0 : lfsr_q[8 +: CH_W];
    assign lfsr_bit = 5'(lfsr_q[16 +: BIT_W]);
    assign lfsr_pat = (lfsr_q[WIDTH-1:0] == '0) ? WIDTH'(1) : lfsr_q[WIDTH-1:0];

    assign budget_spent    = (inj_cnt_q >= budget_q);
    assign fire            = (state_q == S_ARMED) && (pc_i < pc_limit_i)
                           && (lfsr_q[7:0] < threshold_i) && (inj_cnt_q < budget_q);
    assign in_window_state = (state_q == S_HOLD) || (state_q == S_WAIT);
    // Only the first rising edge of error_i inside the window credits this injection.
    assign new_det = in_window_state && error_i && !err_prev_q && !detected_q && (win_q != 16'd0);
    assign det_now = detected_q || new_det;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        bit_d      = bit_q;
        mode_d     = mode_q;
        pat_d      = pat_q;
        inj_cnt_d  = inj_cnt_q;
        det_cnt_d  = det_cnt_q;
        miss_cnt_d = miss_cnt_q;
        budget_d   = budget_q;
        win_d      = win_q;
        hold_d     = hold_q;
        detected_d = detected_q;
        pulse_d    = 1'b0;
        if (!enable_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d    = S_ARMED;
                    inj_cnt_d  = 8'd0;
                    det_cnt_d  = 8'd0;
                    miss_cnt_d = 8'd0;
                    budget_d   = budget_i;
                end
                S_ARMED: begin
                    if (fire) begin
                        ch_d       = lfsr_ch;
                        bit_d      = lfsr_bit;
                        mode_d     = mode_i;
                        pat_d      = lfsr_pat;
                        inj_cnt_d  = sat_inc(inj_cnt_q);
                        win_d      = 16'(DET_WINDOW);
                        hold_d     = 16'(HOLD_CYCLES);
                        detected_d = 1'b0;
                        pulse_d    = 1'b1;
                        state_d    = S_HOLD;
                    end else if (budget_spent) begin
                        state_d = S_DONE;
                    end
                end
                S_HOLD: begin
                    hold_d = hold_q - 16'd1;
                    win_d  = (win_q != 16'd0) ? win_q - 16'd1 : 16'd0;
                    if (new_det) begin
                        detected_d = 1'b1;
                        det_cnt_d  = sat_inc(det_cnt_q);
                    end
                    if (hold_q <= 16'd1) state_d = S_WAIT;
                end
                S_WAIT: begin
                    win_d = (win_q != 16'd0) ? win_q - 16'd1 : 16'd0;
                    if (new_det) begin
                        detected_d = 1'b1;
                        det_cnt_d  = sat_inc(det_cnt_q);
                    end
                    if (det_now || win_q <= 16'd1) begin
                        if (!det_now) miss_cnt_d = sat_inc(miss_cnt_q);
                        state_d = budget_spent ? S_DONE : S_ARMED;
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED;
            ch_q       <= '0;
            bit_q      <= '0;
            mode_q     <= '0;
            pat_q      <= '0;
            inj_cnt_q  <= '0;
            det_cnt_q  <= '0;
            miss_cnt_q <= '0;
            budget_q   <= '0;
            win_q      <= '0;
            hold_q     <= '0;
            detected_q <= 1'b0;
            err_prev_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_nxt;
            ch_q       <= ch_d;
            bit_q      <= bit_d;
            mode_q     <= mode_d;
            pat_q      <= pat_d;
            inj_cnt_q  <= inj_cnt_d;
            det_cnt_q  <= det_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            budget_q   <= budget_d;
            win_q      <= win_d;
            hold_q     <= hold_d;
            detected_q <= detected_d;
            err_prev_q <= error_i;
            pulse_q    <= pulse_d;
        end
    end

    logic [WIDTH-1:0]      word, bmask, faulted;
    logic [N_CH*WIDTH-1:0] data_ov;

    // enable_i gates the overlay directly so an abort cleans the bus in the same cycle.
    always_comb begin
        word  = bus.data_i[ch_q*WIDTH +: WIDTH];
        bmask = WIDTH'(1) << bit_q;
        case (mode_q)
            2'd0:    faulted = word ^ bmask;
            2'd1:    faulted = word & ~bmask;
            2'd2:    faulted = word | bmask;
            default: faulted = word ^ pat_q;
        endcase
        data_ov = bus.data_i;
        if (state_q == S_HOLD && enable_i) data_ov[ch_q*WIDTH +: WIDTH] = faulted;
    end

    assign bus.data_o     = data_ov;
    assign inject_o       = pulse_q;
    assign inject_ch_o    = ch_q;
    assign inject_bit_o   = bit_q;
    assign inject_count_o = inj_cnt_q;
    assign detect_count_o = det_cnt_q;
    assign miss_count_o   = miss_cnt_q;
    assign done_o         = (state_q == S_DONE);
endmodule

// File: tb/tb_fault_injector.sv
// Randomized bench for fault_injector against an injection-age reference model.
module tb_fault_injector;
    localparam int W  = 32;
    localparam int N  = 8;
    localparam int H  = 2;
    localparam int DW = 8;
    localparam int NB = W * N;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, err;
    logic [1:0]  mode;
    logic [7:0]  thr, bud;
    logic [31:0] pc, lim;
    logic        inject_o, done_o;
    logic [2:0]  inject_ch_o;
    logic [4:0]  inject_bit_o;
    logic [7:0]  inj_cnt, det_cnt, miss_cnt;

    fault_injector_if #(.WIDTH(W), .N_CH(N)) bus ();

    fault_injector #(.WIDTH(W), .N_CH(N), .HOLD_CYCLES(H), .DET_WINDOW(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .mode_i(mode), .threshold_i(thr),
        .budget_i(bud), .pc_i(pc), .pc_limit_i(lim), .bus(bus), .error_i(err),
        .inject_o(inject_o), .inject_ch_o(inject_ch_o), .inject_bit_o(inject_bit_o),
        .inject_count_o(inj_cnt), .detect_count_o(det_cnt), .miss_count_o(miss_cnt),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    // Reference model: injection tracked by its age (cycles since first faulted cycle).
    logic [31:0] m_lfsr, m_pat;
    int m_st, m_age, m_ch, m_bit, m_mode, m_ic, m_dc, m_mc, m_bud;
    bit m_det, m_errp, m_pulse;
    int tb_age;

    int g_en, g_thr, g_bud, g_mode, g_pcgate, g_errk, g_data;

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic m_reset();
        m_lfsr = 32'hACE1_2F3B; m_pat = 0;
        m_st = 0; m_age = 0; m_ch = 0; m_bit = 0; m_mode = 0;
        m_ic = 0; m_dc = 0; m_mc = 0; m_bud = 0;
        m_det = 0; m_errp = 0; m_pulse = 0; tb_age = 0;
    endtask

    function automatic logic [NB-1:0] m_data(input logic [NB-1:0] din, input bit en_now);
        logic [NB-1:0] r;
        logic [31:0]   w;
        r = din;
        if (m_st == 2 && m_age <= H && en_now) begin
            w = din[m_ch*W +: W];
            case (m_mode)
                0:       w[m_bit] = ~w[m_bit];
                1:       w[m_bit] = 1'b0;
                2:       w[m_bit] = 1'b1;
                default: w = w ^ m_pat;
            endcase
            r[m_ch*W +: W] = w;
        end
        return r;
    endfunction

    task automatic m_step();
        bit edge_now, pulse;
        edge_now = err && !m_errp;
        pulse = 0;
        if (!en) m_st = 0;
        else begin
            case (m_st)
                0: begin m_st = 1; m_ic = 0; m_dc = 0; m_mc = 0; m_bud = bud; end
                1: begin
                    if (pc < lim && m_lfsr[7:0] < thr && m_ic < m_bud) begin
                        m_ch = m_lfsr[10:8]; m_bit = m_lfsr[20:16]; m_mode = mode;
                        m_pat = (m_lfsr == 0) ? 32'd1 : m_lfsr;
                        m_ic = sat8(m_ic + 1); m_age = 1; m_det = 0; pulse = 1; m_st = 2;
                    end else if (m_ic >= m_bud) m_st = 3;
                end
                2: begin
                    if (edge_now && !m_det && m_age <= DW) begin m_det = 1; m_dc = sat8(m_dc + 1); end
                    if (m_age > H && (m_det || m_age >= DW)) begin
                        if (!m_det) m_mc = sat8(m_mc + 1);
                        m_st = (m_ic >= m_bud) ? 3 : 1;
                    end else m_age++;
                end
                default: ;
            endcase
        end
        m_errp = err;
        m_lfsr = lfsr_next(m_lfsr);
        m_pulse = pulse;
    endtask

    task automatic drive_check_step();
        en  = (g_en < 0) ? ($urandom_range(0, 49) != 0) : g_en[0];
        thr = 8'(g_thr);
        bud = 8'(g_bud);
        mode = (g_mode < 0) ? 2'($urandom_range(0, 3)) : 2'(g_mode);
        if (g_pcgate == 1 || (g_pcgate < 0 && $urandom_range(0, 3) == 0)) begin
            lim = $urandom >> 1; pc = lim + $urandom_range(0, 1000);
        end else begin
            lim = 32'hFFFF_FFFF; pc = $urandom >> 1;
        end
        if (g_errk < 0)       err = ($urandom_range(0, 3) == 0);
        else if (g_errk == 0) err = 1'b0;
        else                  err = (tb_age == g_errk) || (tb_age == g_errk + 1);
        for (int i = 0; i < N; i++)
            bus.data_i[i*W +: W] = (g_data == 1) ? 32'hFFFF_FFFF : (g_data == 2) ? 32'h0 : $urandom;
        #1;
        check("data_o",     bus.data_o,   m_data(bus.data_i, en));
        check("inject_o",   inject_o,     m_pulse);
        check("inject_ch",  inject_ch_o,  m_ch);
        check("inject_bit", inject_bit_o, m_bit);
        check("inj_cnt",    inj_cnt,      m_ic);
        check("det_cnt",    det_cnt,      m_dc);
        check("miss_cnt",   miss_cnt,     m_mc);
        check("done",       done_o,       m_st == 3);
        m_step();
        if (m_pulse) tb_age = 1;
        else if (tb_age > 0 && tb_age < 1000) tb_age++;
    endtask

    task automatic cycle();
        @(negedge clk);
        drive_check_step();
    endtask

    task automatic phase(input int ncyc, input int t, input int b, input int md,
                         input int pcg, input int ek, input int dk);
        int en_save;
        en_save = g_en;
        g_en = 0;
        repeat (2) cycle();
        g_en = en_save; g_thr = t; g_bud = b; g_mode = md; g_pcgate = pcg; g_errk = ek; g_data = dk;
        repeat (ncyc) cycle();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_inject"}, inject_o, 1'b0);
        check({tag, "_ch"},     inject_ch_o, 3'd0);
        check({tag, "_bit"},    inject_bit_o, 5'd0);
        check({tag, "_ic"},     inj_cnt, 8'd0);
        check({tag, "_dc"},     det_cnt, 8'd0);
        check({tag, "_mc"},     miss_cnt, 8'd0);
        check({tag, "_done"},   done_o, 1'b0);
        check({tag, "_data"},   bus.data_o, bus.data_i);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; en = 1'b0; err = 1'b0; mode = 2'd0; thr = 8'd0; bud = 8'd0;
        pc = 32'd0; lim = 32'd0;
        for (int i = 0; i < N; i++) bus.data_i[i*W +: W] = $urandom;
        g_en = 1; g_thr = 0; g_bud = 0; g_mode = 0; g_pcgate = 0; g_errk = 0; g_data = 0;
        m_reset();
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive_check_step();

        // Certain injection, bit-flip, no detection.
        phase(80, 255, 3, 0, 0, 0, 0);
        check("p1_ic", inj_cnt, 8'd3);
        check("p1_mc", miss_cnt, 8'd3);
        check("p1_dc", det_cnt, 8'd0);
        check("p1_done", done_o, 1'b1);

        // Detection 4 cycles into the window, at the window's last cycle, and just past it.
        phase(60, 255, 2, -1, 0, 4, 0);
        check("p2_dc", det_cnt, 8'd2);
        check("p2_mc", miss_cnt, 8'd0);
        phase(60, 255, 2, -1, 0, DW, 0);
        check("p3_dc", det_cnt, 8'd2);
        phase(60, 255, 2, -1, 0, DW + 1, 0);
        check("p4_dc", det_cnt, 8'd0);
        check("p4_mc", miss_cnt, 8'd2);

        // Fault modes on constant data.
        phase(60, 255, 4, 1, 0, 0, 1);
        phase(60, 255, 4, 2, 0, 0, 2);
        phase(60, 200, 4, 3, 0, -1, 0);

        // Gating: pc out of range, zero threshold, zero budget.
        phase(1000, 255, 5, -1, 1, 0, 0);
        check("p6_pc_ic", inj_cnt, 8'd0);
        check("p6_pc_done", done_o, 1'b0);
        phase(1000, 0, 5, -1, 0, 0, 0);
        check("p6_thr_ic", inj_cnt, 8'd0);
        phase(10, 255, 0, -1, 0, 0, 0);
        check("p7_ic", inj_cnt, 8'd0);
        check("p7_done", done_o, 1'b1);

        // Randomized campaigns with enable drops and noisy error_i.
        g_en = -1;
        for (int k = 0; k < 10; k++)
            phase(150, $urandom_range(0, 255), $urandom_range(0, 6), -1, -1, -1, 0);
        g_en = 1;

        // Abort mid-HOLD, then re-arm.
        phase(0, 255, 5, 0, 0, 0, 0);
        n = 0;
        while (m_st != 2 && n < 50) begin cycle(); n++; end
        check("p9_reach_hold", m_st == 2, 1'b1);
        g_en = 0;
        cycle();
        check("p9_abort_clean", bus.data_o, bus.data_i);
        g_en = 1; g_thr = 0;
        cycle();
        cycle();
        check("p9_rearm_ic", inj_cnt, 8'd0);
        check("p9_rearm_mc", miss_cnt, 8'd0);

        // Asynchronous reset while waiting in the window.
        phase(0, 255, 5, 0, 0, 0, 0);
        n = 0;
        while (!(m_st == 2 && m_age > H) && n < 60) begin cycle(); n++; end
        check("p10_reach_wait", (m_st == 2 && m_age > H), 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async");
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_check_step();
        phase(40, 255, 2, -1, 0, 4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
